// File: rtl/ascon_pack.sv
// Shared Ascon types and constants for the permutation datapath.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam int NB_COLS = 64;

  typedef enum logic {IDLE, BUSY} type_subst_fsm;

  // Column-counter width: max(1, clog2(NB_COLS / p)).
  function automatic int subst_cnt_width(int p);
    int n;
    if (p <= 0) return 1;
    n = NB_COLS / p;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ascon_sbox.sv
// Ascon 5-bit S-box, bitsliced form; input bit 4 is row 0.
module ascon_sbox (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

  logic a0, a1, a2, a3, a4;
  logic b0, b1, b2, b3, b4;

  always_comb begin
    a0 = x_i[4] ^ x_i[0];
    a1 = x_i[3];
    a2 = x_i[2] ^ x_i[3];
    a3 = x_i[1];
    a4 = x_i[0] ^ x_i[1];
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    y_o = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};
  end

endmodule

// File: rtl/substitution_layer_folded.sv
// Folded Ascon substitution layer: SBOX_PER_CYCLE columns per cycle, done_o after 64/SBOX_PER_CYCLE cycles.
// Optional SUBST_CLEAR_EN adds clear_i, a synchronous abort that wins over start_i.
module substitution_layer_folded
  import ascon_pack::*;
#(
  parameter int SBOX_PER_CYCLE = 16
) (
  input  logic      clock_i,
  input  logic      resetb_i,
`ifdef SUBST_CLEAR_EN
  input  logic      clear_i,
`endif
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam int NCYC = NB_COLS / SBOX_PER_CYCLE;
  localparam int CW   = subst_cnt_width(SBOX_PER_CYCLE);

  if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 && SBOX_PER_CYCLE != 4 &&
      SBOX_PER_CYCLE != 8 && SBOX_PER_CYCLE != 16 && SBOX_PER_CYCLE != 32 &&
      SBOX_PER_CYCLE != 64) begin : g_bad_param
    $error("SBOX_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
  end

  type_subst_fsm  fsm_q, fsm_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  type_state      state_q, state_d, state_wb;
  logic           done_q, done_d;
  logic [5:0]     base;
  logic [4:0]     sbox_in  [SBOX_PER_CYCLE];
  logic [4:0]     sbox_out [SBOX_PER_CYCLE];

  always_comb base = 6'(int'(cnt_q) * SBOX_PER_CYCLE);

  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_sbox
    always_comb sbox_in[g] = {state_q[0][base + 6'(g)], state_q[1][base + 6'(g)],
                              state_q[2][base + 6'(g)], state_q[3][base + 6'(g)],
                              state_q[4][base + 6'(g)]};
    ascon_sbox u_sbox (
      .x_i (sbox_in[g]),
      .y_o (sbox_out[g])
    );
  end

  // Only the selected slice of columns is rewritten; the rest pass through.
  always_comb begin
    state_wb = state_q;
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      for (int r = 0; r < 5; r++) begin
        state_wb[r][base + 6'(j)] = sbox_out[j][4 - r];
      end
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
`ifdef SUBST_CLEAR_EN
    if (clear_i) begin
      fsm_d   = IDLE;
      cnt_d   = '0;
      state_d = '0;
    end else
`endif
    begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_d = state_i;
            cnt_d   = '0;
            fsm_d   = BUSY;
          end
        end
        BUSY: begin
          state_d = state_wb;
          if (cnt_q == CW'(NCYC - 1)) begin
            cnt_d  = '0;
            fsm_d  = IDLE;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = (fsm_q == BUSY);
  assign done_o  = done_q;

endmodule

// File: tb/tb_substitution_layer_folded.sv
// Scoreboard bench: four instances (P = 16, 1, 8, 64) driven by directed vectors.
module tb_substitution_layer_folded;
  import ascon_pack::*;

  localparam logic [4:0] SBT [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    int        id;
    type_state exp;
    int        due;
  } sb_t;

  logic      clk = 1'b0;
  logic      resetb;
  logic      start [4];
  type_state sin   [4];
  type_state st_o  [4];
  logic      busy  [4];
  logic      done  [4];
`ifdef SUBST_CLEAR_EN
  logic      clear;
`endif

  int  cyc = 0;
  int  applied = 0;
  int  errors = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int PV = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 8 : 64;
    substitution_layer_folded #(.SBOX_PER_CYCLE(PV)) u_dut (
      .clock_i  (clk),
      .resetb_i (resetb),
`ifdef SUBST_CLEAR_EN
      .clear_i  (clear),
`endif
      .start_i  (start[g]),
      .state_i  (sin[g]),
      .state_o  (st_o[g]),
      .busy_o   (busy[g]),
      .done_o   (done[g])
    );
  end

  function automatic int ncyc(int k);
    case (k)
      0: return 4;
      1: return 64;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic type_state model(type_state s);
    type_state  r;
    logic [4:0] x, y;
    for (int i = 0; i < 64; i++) begin
      x = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
      y = SBT[x];
      for (int w = 0; w < 5; w++) r[w][i] = y[4 - w];
    end
    return r;
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int r = 0; r < 5; r++) s[r] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_st(string nm, type_state a, type_state e);
    applied++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    applied++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic drop_expect(int k);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].id == k) sbq.delete(i);
  endtask

  function automatic int pending(int k);
    int n = 0;
    foreach (sbq[i]) if (sbq[i].id == k) n++;
    return n;
  endfunction

  task automatic issue(int k, type_state s, type_state e);
    sb_t t;
    @(negedge clk);
    start[k] = 1'b1;
    sin[k]   = s;
    t.id = k; t.exp = e; t.due = cyc + 1 + ncyc(k);
    sbq.push_back(t);
    @(negedge clk);
    start[k] = 1'b0;
    sin[k]   = ~s;
  endtask

  task automatic wait_idle(int k);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy[k] && pending(k) == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk_int("wait_idle_timeout", ok, 1);
  endtask

  // Monitor: every done_o must match the oldest expectation for that instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done[k] === 1'b1) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (sbq[i].id == k) begin
            idx = i;
            break;
          end
        if (idx < 0) begin
          applied++;
          errors++;
          $display("FAIL unexpected_done: instance %0d at cycle %0d, none expected", k, cyc);
        end else begin
          chk_st($sformatf("result_inst%0d", k), st_o[k], sbq[idx].exp);
          chk_int($sformatf("latency_inst%0d", k), cyc, sbq[idx].due);
          sbq.delete(idx);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    type_state z, ones, e, a, b;
    sb_t       t;
    resetb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0;
      sin[k]   = '0;
    end
`ifdef SUBST_CLEAR_EN
    clear = 1'b0;
`endif
    z    = '0;
    ones = '1;
    repeat (2) @(negedge clk);
    chk_st("reset_state", st_o[0], z);
    chk_int("reset_busy", int'(busy[0]), 0);
    chk_int("reset_done", int'(done[0]), 0);
    resetb = 1'b1;

    // All-zero: S(0)=0x04 sets row 2 only.
    e = '0; e[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(0, z, e);
    wait_idle(0);

    // All-ones: S(0x1F)=0x17 clears row 1 only.
    e = '1; e[1] = 64'h0;
    issue(0, ones, e);
    wait_idle(0);

    // Single column 5 = 0x01 -> 0x0B; others 0 -> 0x04, on every fold factor.
    a = '0; a[4][5] = 1'b1;
    e = '0; e[2] = ~64'h20; e[1] = 64'h20; e[3] = 64'h20; e[4] = 64'h20;
    for (int k = 0; k < 4; k++) issue(k, a, e);
    for (int k = 0; k < 4; k++) wait_idle(k);

    // Random states on all fold factors in parallel.
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) begin
        a = rnd_state();
        issue(k, a, model(a));
      end
      for (int k = 0; k < 4; k++) wait_idle(k);
    end

    // start_i held through BUSY with changing state_i: one operation only.
    a = rnd_state();
    @(negedge clk);
    start[0] = 1'b1; sin[0] = a;
    t.id = 0; t.exp = model(a); t.due = cyc + 1 + ncyc(0);
    sbq.push_back(t);
    for (int i = 0; i < ncyc(0); i++) begin
      @(negedge clk);
      sin[0] = rnd_state();
    end
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk_int("hold_start_busy", int'(busy[0]), 0);
    wait_idle(0);

    // Back-to-back: new start in the done_o cycle, for P=16 and P=64.
    for (int k = 0; k < 4; k += 3) begin
      a = rnd_state();
      b = rnd_state();
      issue(k, a, model(a));
      for (int i = 0; i < 200 && !done[k]; i++) @(negedge clk);
      start[k] = 1'b1; sin[k] = b;
      t.id = k; t.exp = model(b); t.due = cyc + 1 + ncyc(k);
      sbq.push_back(t);
      @(negedge clk);
      start[k] = 1'b0;
      wait_idle(k);
    end

    // Asynchronous reset in the middle of a P=1 operation.
    a = rnd_state();
    issue(1, a, model(a));
    repeat (3) @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    chk_st("reset_mid_state", st_o[1], z);
    chk_int("reset_mid_busy", int'(busy[1]), 0);
    chk_int("reset_mid_done", int'(done[1]), 0);
    drop_expect(1);
    @(negedge clk);
    resetb = 1'b1;
    repeat (70) @(negedge clk);
    chk_int("reset_mid_no_restart", int'(busy[1]), 0);

`ifdef SUBST_CLEAR_EN
    a = rnd_state();
    issue(0, a, model(a));
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drop_expect(0);
    chk_int("clear_busy", int'(busy[0]), 0);
    chk_st("clear_state", st_o[0], z);
    chk_int("clear_done", int'(done[0]), 0);
    clear = 1'b1; start[0] = 1'b1; sin[0] = ones;
    @(negedge clk);
    clear = 1'b0; start[0] = 1'b0;
    chk_int("clear_start_busy", int'(busy[0]), 0);
    chk_st("clear_start_state", st_o[0], z);
    repeat (8) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk_int("missing_done", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/substitution_layer_folded.md
Name: substitution_layer_folded

Overview:
- Folded, sequential version of the Ascon substitution layer (p_S).
- Applies the 5-bit Ascon S-box to the 64 columns of a 320-bit state, but only SBOX_PER_CYCLE columns per clock. This trades latency for area.
- Sits inside the permutation datapath between the constant-addition and linear-diffusion layers, and is driven by the permutation FSM through a start/done handshake.

Parameters:
- SBOX_PER_CYCLE, default 16: number of S-box instances, i.e. columns processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64. Any other value triggers an elaboration-time error.

Ports:
- clock_i  input  1  system clock, rising edge
- resetb_i  input  1  asynchronous reset, active low
- start_i  input  1  request to substitute state_i; sampled only when idle
- state_i  input  type_state (5x64)  state to substitute; sampled in the start cycle only
- state_o  output  type_state (5x64)  working register; holds the result when done_o=1 and afterwards
- busy_o  output  1  high while columns are being processed
- done_o  output  1  one-cycle pulse when state_o holds the complete result

Behaviour:
- Reset (resetb_i=0, asynchronous):
  - state_o = all zeros, busy_o = 0, done_o = 0.
  - Column counter = 0, FSM = IDLE.
  - A reset during BUSY aborts the operation immediately; no done_o is produced.
- FSM states: IDLE, BUSY. NCYC = 64/SBOX_PER_CYCLE. Counter width = max(1, clog2(NCYC)).
- IDLE:
  - start_i=1 at an edge: register state_i into the working register, counter=0, go to BUSY, busy_o=1 from the next cycle.
  - start_i=0: state_o holds its value.
- BUSY, cycle k (k = 0..NCYC-1):
  - Columns i = k*P .. k*P+P-1, with P = SBOX_PER_CYCLE and LSB column first, pass through the S-boxes.
  - S-box input is {state[0][i], state[1][i], state[2][i], state[3][i], state[4][i]}; row 0 is the MSB.
  - The outputs are written back to the same column of the working register. All other columns are untouched.
- Termination: at the edge that completes k = NCYC-1:
  - go to IDLE, busy_o=0, done_o=1 for exactly one cycle.
  - Counter wraps to 0.
- Latency: done_o asserts NCYC cycles after the start edge (SBOX_PER_CYCLE=64 gives 1 cycle; 16 gives 4).
- start_i during BUSY is ignored; state_i is not resampled.
- start_i in the same cycle that done_o is high (FSM already IDLE) is accepted. Back-to-back operations therefore have a throughput of one result per NCYC+1 cycles.
- During BUSY, state_o exposes partially substituted data. Consumers use it only on or after done_o.
- No arithmetic. The S-box is pure combinational logic with no carry or width growth.

Optional Feature:
- Macro: SUBST_CLEAR_EN.
- Defined:
  - Adds input port clear_i (1 bit), a synchronous abort.
  - clear_i=1 at an edge forces FSM=IDLE, counter=0, busy_o=0, done_o=0 and zeroes the working register, from any state.
  - clear_i has priority over start_i in the same cycle.
- Undefined: the port is absent, and only resetb_i aborts an operation.

Decomposition:
- ascon_pack additions:
  - localparam NB_COLS = 64.
  - Function or constant computing the counter width from SBOX_PER_CYCLE.
  - FSM state enum type_subst_fsm {IDLE, BUSY}.
  - type_state is reused unchanged.
- Sub-module: the existing ascon_sbox, instantiated SBOX_PER_CYCLE times in a generate loop.
- Column selection is a mux indexed by the counter. Writeback is a demux to the working register.

Test Plan:
- Reset / idle hold: reset with resetb_i low mid-BUSY -> state_o=0, busy_o=0, done_o=0 immediately; no later done_o.
- All-zero state, P=16:
  - Stimulus: state_i=0, start.
  - Response: done_o after 4 cycles; state_o[2]=64'hFFFF_FFFF_FFFF_FFFF, rows 0, 1, 3, 4 = 0 (S(0)=0x04).
- All-ones state, P=16:
  - Stimulus: state_i all ones.
  - Response: rows 0, 2, 3, 4 = all ones, row 1 = 0 (S(0x1F)=0x17).
- Sweep SBOX_PER_CYCLE ∈ {1, 8, 64} with a random state:
  - Result matches the 64-column combinational reference model.
  - done_o latency is 64, 8 and 1 cycles respectively.
- Handshake:
  - start_i held high through BUSY -> single operation, no restart.
  - start_i asserted in the done_o cycle with a new state -> second result correct, done_o NCYC+1 cycles after the first.
- SUBST_CLEAR_EN:
  - clear_i at cycle 2 of 4 -> busy_o=0, state_o=0, no done_o.
  - clear_i and start_i together -> stays IDLE.
